// File: rtl/ysyx_25020037_icache_pkg.sv
// Shared definitions for the IFU instruction cache: controller states,
// AXI response codes and the cacheable-region test.
package ysyx_25020037_icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_AR,
    S_MISS_R,
    S_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic logic is_cacheable(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/ysyx_25020037_icache_array.sv
// Direct-mapped tag/data storage: combinational read, synchronous write,
// valid vector cleared by reset or flush.
module ysyx_25020037_icache_array #(
  parameter int unsigned NLINES = 16,
  parameter int unsigned IDX    = $clog2(NLINES),
  parameter int unsigned TAG    = 30 - IDX
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic [IDX-1:0]  i_idx,
  output logic            o_valid,
  output logic [TAG-1:0]  o_tag,
  output logic [31:0]     o_data,
  input  logic            i_wr_en,
  input  logic [TAG-1:0]  i_wr_tag,
  input  logic [31:0]     i_wr_data
);

  logic [NLINES-1:0] r_valid;
  logic [TAG-1:0]    r_tag  [NLINES];
  logic [31:0]       r_data [NLINES];

  // Flush wins over a same-cycle fill so a fence never leaves a line valid.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_idx]  <= i_wr_tag;
      r_data[i_idx] <= i_wr_data;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];

endmodule

// File: rtl/ysyx_25020037_icache.sv
// Direct-mapped single-word-line I-cache between the IFU AXI4-Lite read port
// and the crossbar; one outstanding request, hit/miss performance counters.
module ysyx_25020037_icache
  import ysyx_25020037_icache_pkg::*;
#(
  parameter int unsigned NLINES     = 16,
  parameter logic [31:0] CACHE_BASE = 32'h8000_0000,
  parameter logic [31:0] CACHE_MASK = 32'hF800_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ifu_araddr,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  output logic [31:0] mem_araddr,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic        fence_i,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned IDX = $clog2(NLINES);
  localparam int unsigned TAG = 30 - IDX;

  state_e      r_state;
  logic [31:2] r_addr;
  logic        r_cacheable;
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        r_mem_arvalid;
  logic [31:0] r_mem_araddr;
  logic        r_mem_rready;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  logic [IDX-1:0] w_idx;
  logic [TAG-1:0] w_addr_tag;
  logic           w_line_valid;
  logic [TAG-1:0] w_line_tag;
  logic [31:0]    w_line_data;
  logic           w_hit;
  logic           w_fill;

  assign w_idx      = r_addr[IDX+1:2];
  assign w_addr_tag = r_addr[31:IDX+2];

  // A fence in the lookup cycle forces a miss; error responses are never cached.
  assign w_hit  = r_cacheable && w_line_valid && (w_line_tag == w_addr_tag) && !fence_i;
  assign w_fill = (r_state == S_MISS_R) && mem_rvalid && r_cacheable && (mem_rresp == RESP_OKAY);

  ysyx_25020037_icache_array #(
    .NLINES (NLINES)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (fence_i),
    .i_idx     (w_idx),
    .o_valid   (w_line_valid),
    .o_tag     (w_line_tag),
    .o_data    (w_line_data),
    .i_wr_en   (w_fill),
    .i_wr_tag  (w_addr_tag),
    .i_wr_data (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_cacheable   <= 1'b0;
      r_arready     <= 1'b0;
      r_rvalid      <= 1'b0;
      r_rdata       <= '0;
      r_rresp       <= '0;
      r_mem_arvalid <= 1'b0;
      r_mem_araddr  <= '0;
      r_mem_rready  <= 1'b0;
      r_hit_cnt     <= '0;
      r_miss_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_arready) begin
            r_arready <= 1'b1;
          end else if (ifu_arvalid) begin
            r_addr      <= ifu_araddr[31:2];
            r_cacheable <= is_cacheable(ifu_araddr, CACHE_BASE, CACHE_MASK);
            r_arready   <= 1'b0;
            r_state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_rdata   <= w_line_data;
            r_rresp   <= RESP_OKAY;
            r_rvalid  <= 1'b1;
            r_hit_cnt <= r_hit_cnt + 32'd1;
            r_state   <= S_RESP;
          end else begin
            r_miss_cnt    <= r_miss_cnt + 32'd1;
            r_mem_arvalid <= 1'b1;
            r_mem_araddr  <= {r_addr, 2'b00};
            r_state       <= S_MISS_AR;
          end
        end
        S_MISS_AR: begin
          if (mem_arready) begin
            r_mem_arvalid <= 1'b0;
            r_mem_rready  <= 1'b1;
            r_state       <= S_MISS_R;
          end
        end
        S_MISS_R: begin
          if (mem_rvalid) begin
            r_rdata      <= mem_rdata;
            r_rresp      <= mem_rresp;
            r_mem_rready <= 1'b0;
            r_rvalid     <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (ifu_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ifu_arready = r_arready;
  assign ifu_rvalid  = r_rvalid;
  assign ifu_rdata   = r_rdata;
  assign ifu_rresp   = r_rresp;
  assign mem_arvalid = r_mem_arvalid;
  assign mem_araddr  = r_mem_araddr;
  assign mem_rready  = r_mem_rready;
  assign hit_cnt     = r_hit_cnt;
  assign miss_cnt    = r_miss_cnt;

endmodule
